// File: rtl/mp3_bitstream_feeder.sv
// mp3_bitstream_feeder: byte ring buffer between an MP3 byte source and the
// decoder's show-ahead word input (fifo_datain / fifo_ren).
// Host beats of IN_BYTES bytes (earliest byte in the MSBs) are appended to a
// 2^ADDR_W-byte ring. The ring is unloaded OUT_BYTES at a time into a
// registered output word. After the in_last beat has been accepted, the tail
// is drained, with zero padding in the low bytes of the final word.
// Optional feature macro: MP3_FEEDER_STATS_EN enables the byte_count and
// underflow_count statistics counters. When it is undefined, both are tied to 0.
//
// Handshake: a host beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on level/state. A word transfers to the decoder on an
// edge where fifo_ren && fifo_valid. fifo_ren while fifo_valid=0 is an
// underflow and is otherwise ignored.
module mp3_bitstream_feeder #(
  parameter int IN_BYTES  = 1,
  parameter int OUT_BYTES = 2,
  parameter int ADDR_W    = 10
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   flush,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [2:0]             in_nbytes,
  output logic                   in_ready,
  output logic [8*OUT_BYTES-1:0] fifo_datain,
  output logic                   fifo_valid,
  input  logic                   fifo_ren,
  output logic                   fifo_last,
  output logic                   eos_done,
  output logic                   underflow,
  output logic [ADDR_W:0]        level,
  output logic [31:0]            byte_count,
  output logic [15:0]            underflow_count,
  output logic [1:0]             dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        level_q, level_d;
  logic [8*OUT_BYTES-1:0] word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   underflow_q, underflow_d;

  logic                   clear;
  logic                   accept;
  logic                   pop;
  logic                   load_slot;
  logic                   uf_event;
  logic [3:0]             wbytes;
  logic [ADDR_W:0]        free_bytes;
  logic [ADDR_W:0]        loaded;

  assign clear      = RST_I | flush;
  assign free_bytes = (ADDR_W+1)'(DEPTH) - level_q;
  assign in_ready   = (free_bytes >= (ADDR_W+1)'(IN_BYTES)) &&
                      ((state_q == S_EMPTY) || (state_q == S_STREAM));
  assign accept     = in_valid & in_ready;
  // A short byte count is only honoured on the final beat.
  assign wbytes     = in_last ? {1'b0, in_nbytes} : 4'(IN_BYTES);
  assign pop        = fifo_ren & valid_q;
  assign uf_event   = fifo_ren & ~valid_q;
  // The output register may be refilled when it is empty or being consumed.
  assign load_slot  = ~valid_q | pop;

  // Ring storage: append the accepted bytes at the write pointer.
  always_ff @(posedge CLK_I) begin
    if (accept) begin
      for (int k = 0; k < IN_BYTES; k++) begin
        if (k < int'(wbytes)) begin
          mem_q[wr_ptr_q + ADDR_W'(k)] <= in_data[8*(IN_BYTES-k)-1 -: 8];
        end
      end
    end
  end

  // Next-state logic: pointers, level, output word and stream phase.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    word_d      = word_q;
    valid_d     = valid_q;
    last_d      = last_q;
    underflow_d = underflow_q | uf_event;
    loaded      = '0;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(wbytes);
    end

    // The load uses only bytes already in the ring before this edge.
    if (load_slot) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (level_q >= (ADDR_W+1)'(OUT_BYTES)) begin
        for (int k = 0; k < OUT_BYTES; k++) begin
          word_d[8*(OUT_BYTES-k)-1 -: 8] = mem_q[rd_ptr_q + ADDR_W'(k)];
        end
        valid_d = 1'b1;
        last_d  = (state_q == S_DRAIN) && (level_q == (ADDR_W+1)'(OUT_BYTES));
        loaded  = (ADDR_W+1)'(OUT_BYTES);
      end else if ((state_q == S_DRAIN) && (level_q != '0)) begin
        for (int k = 0; k < OUT_BYTES; k++) begin
          word_d[8*(OUT_BYTES-k)-1 -: 8] =
            (k < int'(level_q)) ? mem_q[rd_ptr_q + ADDR_W'(k)] : 8'h00;
        end
        valid_d = 1'b1;
        last_d  = 1'b1;
        loaded  = level_q;
      end
      rd_ptr_d = rd_ptr_q + loaded[ADDR_W-1:0];
    end

    level_d = level_q + (accept ? (ADDR_W+1)'(wbytes) : '0) - loaded;

    case (state_q)
      S_EMPTY:  if (accept) state_d = in_last ? S_DRAIN : S_STREAM;
      S_STREAM: if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN:  if ((pop && last_q) || (!valid_q && (level_q == '0))) state_d = S_DONE;
      default:  state_d = state_q;
    endcase
  end

  // State register; reset and flush clear everything on the same edge.
  always_ff @(posedge CLK_I) begin
    if (clear) begin
      state_q     <= S_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_datain = word_q;
  assign fifo_valid  = valid_q;
  assign fifo_last   = last_q;
  assign eos_done    = (state_q == S_DONE);
  assign underflow   = underflow_q;
  assign level       = level_q;
  assign dbg_state   = state_q;

`ifdef MP3_FEEDER_STATS_EN
  logic [31:0] byte_count_q;
  logic [15:0] uf_count_q;

  // Statistics: bytes accepted (wrapping) and underflow events (saturating).
  always_ff @(posedge CLK_I) begin
    if (clear) begin
      byte_count_q <= '0;
      uf_count_q   <= '0;
    end else begin
      if (accept) byte_count_q <= byte_count_q + 32'(wbytes);
      if (uf_event && (uf_count_q != 16'hFFFF)) uf_count_q <= uf_count_q + 16'd1;
    end
  end

  assign byte_count      = byte_count_q;
  assign underflow_count = uf_count_q;
`else
  assign byte_count      = '0;
  assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_mp3_bitstream_feeder.sv
// Bench for mp3_bitstream_feeder (IN_BYTES=4, OUT_BYTES=2, ADDR_W=10).
// A byte-queue model of the buffer tracks what the outputs must be, and a
// negedge process compares every output against it. Directed sections pin
// hand-computed values.
module tb_mp3_bitstream_feeder;

  localparam int IN_B  = 4;
  localparam int OUT_B = 2;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef MP3_FEEDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        in_ready;
  logic [15:0] fifo_datain;
  logic        fifo_valid;
  logic        fifo_ren;
  logic        fifo_last;
  logic        eos_done;
  logic        underflow;
  logic [AW:0] level;
  logic [31:0] byte_count;
  logic [15:0] underflow_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mp3_bitstream_feeder #(.IN_BYTES(IN_B), .OUT_BYTES(OUT_B), .ADDR_W(AW)) dut (
    .CLK_I(clk), .RST_I(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_nbytes(in_nbytes),
    .in_ready(in_ready), .fifo_datain(fifo_datain), .fifo_valid(fifo_valid),
    .fifo_ren(fifo_ren), .fifo_last(fifo_last), .eos_done(eos_done),
    .underflow(underflow), .level(level), .byte_count(byte_count),
    .underflow_count(underflow_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state / model ----------------
  int          checks   = 0;
  int          failures = 0;
  bit          cmp_en   = 1'b0;
  logic [7:0]  exp_q[$];          // bytes held in the ring
  logic [15:0] m_word;
  bit          m_valid, m_last, m_drain, m_done, m_uf;
  logic [31:0] m_bc;
  logic [15:0] m_ufc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_ready();
    return ((DEPTH - exp_q.size()) >= IN_B) && !m_drain && !m_done;
  endfunction

  // Model update on each edge from the inputs that were applied for it.
  always @(posedge clk) begin : model_blk
    bit          acc, do_pop, was_last;
    int          n;
    logic [7:0]  b0, b1;
    if (rst || flush) begin
      exp_q.delete();
      m_word = '0; m_valid = 0; m_last = 0; m_drain = 0; m_done = 0; m_uf = 0;
      m_bc = '0; m_ufc = '0;
    end else begin
      acc    = in_valid && model_ready();
      n      = in_last ? int'(in_nbytes) : IN_B;
      do_pop = fifo_ren && m_valid;
      if (fifo_ren && !m_valid) begin
        m_uf = 1;
        if (m_ufc != 16'hFFFF) m_ufc = m_ufc + 16'd1;
      end
      if (!m_valid || do_pop) begin
        was_last = m_last;
        if (exp_q.size() >= OUT_B) begin
          b0 = exp_q.pop_front();
          b1 = exp_q.pop_front();
          m_word = {b0, b1}; m_valid = 1;
          m_last = m_drain && (exp_q.size() == 0);
        end else if (m_drain && exp_q.size() == 1) begin
          b0 = exp_q.pop_front();
          m_word = {b0, 8'h00}; m_valid = 1; m_last = 1;
        end else begin
          m_valid = 0; m_last = 0;
        end
        if (do_pop && was_last) m_done = 1;
      end
      if (acc) begin
        for (int i = 0; i < n; i++) exp_q.push_back(in_data[31-8*i -: 8]);
        m_bc = m_bc + 32'(n);
        if (in_last) m_drain = 1;
      end
    end
  end

  // Compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",   32'(in_ready),   32'(model_ready()));
      chk("fifo_valid", 32'(fifo_valid), 32'(m_valid));
      chk("fifo_last",  32'(fifo_last),  32'(m_last));
      if (m_valid) chk("fifo_datain", 32'(fifo_datain), 32'(m_word));
      chk("eos_done",   32'(eos_done),   32'(m_done));
      chk("underflow",  32'(underflow),  32'(m_uf));
      chk("level",      32'(level),      32'(exp_q.size()));
      chk("byte_count", byte_count,      STATS ? m_bc : 32'd0);
      chk("uf_count",   32'(underflow_count), STATS ? 32'(m_ufc) : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush();
    flush = 1; in_valid = 0; in_last = 0; fifo_ren = 0;
    tick();
    flush = 0;
  endtask

  task automatic run_stream(input int nbeats, input bit with_last, input int pv,
                            input int pr, input int max_cycles);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    in_data = $urandom();
    while (sent < nbeats && cyc < max_cycles) begin
      in_valid  = ($urandom_range(0, 99) < pv);
      in_last   = with_last && (sent == nbeats - 1);
      in_nbytes = in_last ? 3'($urandom_range(1, 4)) : 3'd4;
      fifo_ren  = ($urandom_range(0, 99) < pr);
      acc = in_valid && model_ready();
      tick();
      if (acc) begin
        sent++;
        in_data = $urandom();
      end
      cyc++;
    end
    in_valid = 0; in_last = 0; fifo_ren = 0;
    if (sent < nbeats) chk("stream_timeout", 32'(sent), 32'(nbeats));
  endtask

  task automatic drain_all(input bit with_last, input int pr, input int max_cycles);
    int cyc = 0;
    in_valid = 0;
    while (cyc < max_cycles && (with_last ? !m_done : (m_valid || exp_q.size() != 0))) begin
      fifo_ren = ($urandom_range(0, 99) < pr);
      tick();
      cyc++;
    end
    fifo_ren = 0;
    if (with_last) chk("drain_eos", 32'(eos_done), 32'd1);
    else           chk("drain_empty", 32'(level) + 32'(fifo_valid), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int vld_cycles;
    rst = 1; flush = 0; in_data = '0; in_valid = 0; in_last = 0; in_nbytes = 3'd4; fifo_ren = 0;
    tick();
    cmp_en = 1;
    tick();
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_datain",   32'(fifo_datain), 32'd0);
    chk("rst_valid",    32'(fifo_valid), 32'd0);
    chk("rst_level",    32'(level), 32'd0);
    chk("rst_eos",      32'(eos_done), 32'd0);

    // First beat: words 0x4944, 0x3304, valid one edge after acceptance.
    in_data = 32'h4944_3304; in_valid = 1;
    tick();
    in_valid = 0;
    chk("lat_valid_n", 32'(fifo_valid), 32'd0);
    tick();
    chk("lat_valid_n1", 32'(fifo_valid), 32'd1);
    chk("word0", 32'(fifo_datain), 32'h4944);
    chk("word0_level", 32'(level), 32'd2);
    fifo_ren = 1;
    tick();
    chk("word1", 32'(fifo_datain), 32'h3304);
    tick();
    fifo_ren = 0;
    chk("popped_empty", 32'(fifo_valid), 32'd0);

    // Three cycles of reads against an empty buffer.
    fifo_ren = 1;
    repeat (3) tick();
    fifo_ren = 0;
    chk("uf_flag", 32'(underflow), 32'd1);
    chk("uf_count3", 32'(underflow_count), STATS ? 32'd3 : 32'd0);

    // Flush mid-stream with a beat and a read pending on the same edge.
    in_valid = 1;
    repeat (3) begin in_data = $urandom(); tick(); end
    flush = 1; in_valid = 1; fifo_ren = 1;
    tick();
    flush = 0; in_valid = 0; fifo_ren = 0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(fifo_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_uf",    32'(underflow), 32'd0);
    chk("flush_bc",    byte_count, 32'd0);

    // Fill with no reads until in_ready drops.
    for (int i = 0; i < 400 && model_ready(); i++) begin
      in_valid = 1; in_data = $urandom();
      tick();
    end
    in_valid = 0;
    chk("full_level", 32'(level), 32'd1022);
    chk("full_ready", 32'(in_ready), 32'd0);
    fifo_ren = 1;
    tick();
    fifo_ren = 0;
    chk("pop1_level", 32'(level), 32'd1020);
    chk("pop1_ready", 32'(in_ready), 32'd1);
    drain_all(0, 100, 2000);

    // Continuous write and read: one word per cycle, level +2 per cycle.
    vld_cycles = 0;
    in_valid = 1; fifo_ren = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom();
      tick();
      if (i >= 1 && fifo_valid) vld_cycles++;
    end
    in_valid = 0; fifo_ren = 0;
    chk("thru_level", 32'(level), 32'd42);
    chk("thru_valid", 32'(vld_cycles), 32'd19);
    drain_all(0, 100, 2000);

    // Random traffic, pointers wrap repeatedly.
    run_stream(300, 0, 70, 60, 3000);
    drain_all(0, 60, 3000);

    // Five-byte stream: 0x0102, 0x0304, 0x0500 (last).
    do_flush();
    in_data = 32'h0102_0304; in_valid = 1; in_last = 0;
    tick();
    in_data = 32'h0500_0000; in_last = 1; in_nbytes = 3'd1;
    tick();
    in_valid = 0; in_last = 0;
    chk("eos_w0", 32'(fifo_datain), 32'h0102);
    chk("eos_ready", 32'(in_ready), 32'd0);
    fifo_ren = 1;
    tick();
    chk("eos_w1", 32'(fifo_datain), 32'h0304);
    chk("eos_w1_last", 32'(fifo_last), 32'd0);
    tick();
    chk("eos_w2", 32'(fifo_datain), 32'h0500);
    chk("eos_w2_last", 32'(fifo_last), 32'd1);
    tick();
    chk("eos_done", 32'(eos_done), 32'd1);
    chk("eos_done_ready", 32'(in_ready), 32'd0);
    tick();
    fifo_ren = 0;
    chk("done_uf", 32'(underflow), 32'd1);

    // Stream ending on a word boundary: last full word flagged, no padding.
    do_flush();
    in_data = 32'hAABB_CCDD; in_valid = 1; in_last = 1; in_nbytes = 3'd4;
    tick();
    in_valid = 0; in_last = 0;
    tick();
    tick();
    chk("exact_w0", 32'(fifo_datain), 32'hAABB);
    fifo_ren = 1;
    tick();
    chk("exact_w1", 32'(fifo_datain), 32'hCCDD);
    chk("exact_last", 32'(fifo_last), 32'd1);
    tick();
    fifo_ren = 0;
    chk("exact_eos", 32'(eos_done), 32'd1);

    // Random complete streams with random tail lengths.
    for (int s = 0; s < 3; s++) begin
      do_flush();
      run_stream($urandom_range(1, 30), 1, 80, 50, 2000);
      drain_all(1, 70, 2000);
    end

    do_flush();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mp3_bitstream_feeder.md
# mp3_bitstream_feeder

Parametrised bitstream buffer that sits between the MP3 source (host, SD/Ethernet loader) and the decoder's `fifo_datain`/`fifo_ren` input. It accepts IN_BYTES-wide host beats, stores them in a byte ring buffer, and presents big-endian OUT_BYTES-wide words to the decoder with show-ahead semantics. It adds an explicit end-of-stream drain with zero padding, an underflow flag, and flush.

## Interface
- IN_BYTES, 1: bytes per host beat (1, 2 or 4).
- OUT_BYTES, 2: bytes per decoder word (2 or 4); `fifo_datain` width = 8*OUT_BYTES.
- ADDR_W, 10: ring buffer depth = 2^ADDR_W bytes; must be ≥ 2*max(IN_BYTES,OUT_BYTES).
- CLK_I  in  1  sole clock, rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of buffer and state; same effect as RST_I.
- in_data  in  8*IN_BYTES  host bytes; byte 0 (earliest in file) in MSBs.
- in_valid  in  1  host beat valid.
- in_last  in  1  qualifies the final beat of the stream.
- in_nbytes  in  3  valid bytes in beat, 1..IN_BYTES, MSB-aligned; only honoured with in_last, otherwise IN_BYTES.
- in_ready  out  1  beat accepted on edge where in_valid && in_ready.
- fifo_datain  out  8*OUT_BYTES  current word, registered, earliest byte in MSBs.
- fifo_valid  out  1  fifo_datain holds a valid word.
- fifo_ren  in  1  decoder consumes current word.
- fifo_last  out  1  current word is the final (possibly padded) word.
- eos_done  out  1  final word consumed.
- underflow  out  1  sticky: fifo_ren seen while fifo_valid=0.
- level  out  ADDR_W+1  bytes in ring buffer (excluding output register).
- byte_count  out  32  stats (see Configuration).
- underflow_count  out  16  stats (see Configuration).

## Operation
- States: EMPTY → STREAM (first accepted beat) → DRAIN (beat with in_last accepted) → DONE (word with fifo_last consumed). DONE holds until RST_I/flush.
- in_ready = (free bytes ≥ IN_BYTES) && state ∈ {EMPTY, STREAM}. In DRAIN/DONE in_ready=0; beats are neither accepted nor counted.
- Write: in_nbytes bytes appended at write pointer, pointer and level wrap modulo 2^ADDR_W.
- Output register load: when fifo_valid=0 or (fifo_ren && fifo_valid), load next OUT_BYTES bytes if level ≥ OUT_BYTES; in DRAIN, if 0 < level < OUT_BYTES load remaining bytes in MSBs, pad low bytes with 0x00, set fifo_last. In DRAIN with level=0 and nothing loaded after pop, go DONE.
- in_last beat with level after write a multiple of OUT_BYTES: last full word carries fifo_last, no padding.
- in_last with in_nbytes producing zero new bytes is illegal.
- Simultaneous write and load on one edge: level' = level + written − loaded; pointer logic must not require the written bytes in the same-edge load.
- Underflow: fifo_ren && !fifo_valid sets underflow (sticky), no other effect; no pointer motion.
- fifo_ren in DONE counts as underflow.
- Flush/RST_I mid-stream: pointers, level, output register, flags and state cleared on that edge; any concurrent beat discarded.

## Timing
- Reset values: in_ready=1, fifo_datain=0, fifo_valid=0, fifo_last=0, eos_done=0, underflow=0, level=0, counters=0, state EMPTY.
- Latency: beat accepted at edge N completing ≥OUT_BYTES bytes → fifo_valid=1 after edge N+1.
- Throughput: one word per cycle when fifo_ren held high and level ≥ OUT_BYTES each cycle; one beat per cycle while free space allows.
- eos_done rises on the edge after the fifo_last word is popped.
- in_ready is registered-free combinational from level/state; no combinational path fifo_ren → in_ready.

## Configuration
- MP3_FEEDER_STATS_EN defined: byte_count increments by bytes accepted per beat (wraps at 2^32); underflow_count increments per underflow event, saturates at 0xFFFF; both cleared by RST_I/flush.
- Undefined: byte_count and underflow_count tied to 0, counters not synthesised; all else unchanged.

## Test plan
- IN_BYTES=1, OUT_BYTES=2: write 0x49,0x44,0x33,0x04 → words 0x4944 then 0x3304, fifo_valid one edge after second byte's acceptance.
- Fill 1024 bytes with no reads (ADDR_W=10) → in_ready=0 at level=1024; one pop → level=1022, in_ready=1; pointer wrap data intact.
- 5-byte stream, last beat in_last → words 0x0102, 0x0304, 0x0500 with fifo_last on third; eos_done=1 after its pop; in_ready=0.
- fifo_ren held with empty buffer for 3 cycles → underflow=1, underflow_count=3 (macro defined), 0 (undefined).
- IN_BYTES=4, OUT_BYTES=2, continuous write and ren → sustained one word/cycle, level constant-growing by 2/cycle, no lost or duplicated bytes versus reference byte stream.
- Flush asserted mid-stream with in_valid=1 and fifo_ren=1 → next cycle level=0, fifo_valid=0, state EMPTY, byte_count=0.
